// File: rtl/diff_pkg.sv
// Shared types and constants for the single-wire pulse-width link.
// Holds the frame width, the receiver and transmitter state encodings
// and the symbol classes produced by the receiver's low-time classifier.
package diff_pkg;

   localparam int unsigned FRAME_BITS = 26;
   localparam int unsigned BIT_CNT_W  = 5;

   // Default line timing, in clock cycles.
   localparam int unsigned DEF_DATA_PERIOD  = 20;
   localparam int unsigned DEF_ZERO_MAX_LOW = 7;
   localparam int unsigned DEF_SYNC_MAX_LOW = 12;
   localparam int unsigned DEF_MIN_LOW      = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      DATA = 2'd2,
      ERR  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      GLITCH = 2'd0,
      ZERO   = 2'd1,
      SYNC   = 2'd2,
      ONE    = 2'd3
   } symbol_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_HEAD = 2'd1,
      TX_DATA = 2'd2,
      TX_TAIL = 2'd3
   } tx_state_t;

endpackage

// File: rtl/line_sync_edge.sv
// Brings the asynchronous line into the clock domain and detects its edges.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   line       : raw asynchronous line (idles high)
//   level      : synchronized line level (registered)
//   rise_c     : one-cycle pulse on a synchronized rising edge
//   fall_c     : one-cycle pulse on a synchronized falling edge
module line_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   logic meta;
   logic sync;
   logic dly;

   // Flops reset to 1 to match the idle line, so a line held low at
   // reset release shows up as a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         sync <= 1'b1;
         dly  <= 1'b1;
      end else begin
         meta <= line;
         sync <= meta;
         dly  <= sync;
      end
   end

   assign level  = sync;
   assign rise_c = sync & ~dly;
   assign fall_c = ~sync & dly;

endmodule

// File: rtl/diff_rx.sv
// Receiver for the single-wire pulse-width link.
// Measures each low pulse, classifies it as GLITCH/ZERO/SYNC/ONE and
// assembles SYNC + 26 data bits (MSB first) + SYNC into a frame.
// Ports:
//   clk_in, rst_n_in : clock and asynchronous active-low reset
//   line_in          : asynchronous serial line, idles high
//   data_out         : last good frame
//   valid_out        : one-cycle pulse when data_out updates
//   error_out        : one-cycle pulse on a protocol violation
//   state_out        : current receiver state
module diff_rx
   import diff_pkg::*;
#(
   parameter int unsigned DATA_PERIOD  = DEF_DATA_PERIOD,
   parameter int unsigned ZERO_MAX_LOW = DEF_ZERO_MAX_LOW,
   parameter int unsigned SYNC_MAX_LOW = DEF_SYNC_MAX_LOW,
   parameter int unsigned MIN_LOW      = DEF_MIN_LOW
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  line_in,
   output logic [FRAME_BITS-1:0] data_out,
   output logic                  valid_out,
   output logic                  error_out,
   output logic [1:0]            state_out
);

   localparam int unsigned CNT_W = $clog2(DATA_PERIOD + 1);
   localparam logic [CNT_W-1:0]     PERIOD_C = CNT_W'(DATA_PERIOD);
   localparam logic [CNT_W-1:0]     ZMAX_C   = CNT_W'(ZERO_MAX_LOW);
   localparam logic [CNT_W-1:0]     SMAX_C   = CNT_W'(SYNC_MAX_LOW);
   localparam logic [CNT_W-1:0]     MINL_C   = CNT_W'(MIN_LOW);
   localparam logic [BIT_CNT_W-1:0] FRAME_C  = BIT_CNT_W'(FRAME_BITS);

   logic                  level;
   logic                  rise_c;
   logic                  fall_c;
   logic [CNT_W-1:0]      low_cnt;
   logic [CNT_W-1:0]      high_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   rx_state_t             state;
   symbol_t               sym_c;
   logic                  err_c;
   logic                  done_c;
   logic                  timeout_c;

   line_sync_edge u_sync (
      .clk    (clk_in),
      .rst_n  (rst_n_in),
      .line   (line_in),
      .level  (level),
      .rise_c (rise_c),
      .fall_c (fall_c)
   );

   // Low-time counter: 1 on the falling edge, saturating at the period.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         low_cnt <= '0;
      end else if (fall_c) begin
         low_cnt <= CNT_W'(1);
      end else if (!level && low_cnt != PERIOD_C) begin
         low_cnt <= low_cnt + CNT_W'(1);
      end
   end

   // High-time counter: also restarts on error entry so ERR waits a full
   // period of quiet line before returning to IDLE.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         high_cnt <= '0;
      end else if (!level || err_c) begin
         high_cnt <= '0;
      end else if (high_cnt != PERIOD_C) begin
         high_cnt <= high_cnt + CNT_W'(1);
      end
   end

   // Classify the low time just measured (valid in the rise cycle).
   always_comb begin
      sym_c = ONE;
      if (low_cnt < MINL_C) begin
         sym_c = GLITCH;
      end else if (low_cnt <= ZMAX_C) begin
         sym_c = ZERO;
      end else if (low_cnt <= SMAX_C) begin
         sym_c = SYNC;
      end
   end

   // Protocol checks and frame completion for the current cycle.
   always_comb begin
      err_c     = 1'b0;
      done_c    = 1'b0;
      timeout_c = (!level && low_cnt == PERIOD_C) || (level && high_cnt == PERIOD_C);
      case (state)
         HEAD: begin
            if (timeout_c || (rise_c && sym_c != SYNC)) begin
               err_c = 1'b1;
            end
         end
         DATA: begin
            if (timeout_c) begin
               err_c = 1'b1;
            end else if (rise_c) begin
               if (bit_cnt == FRAME_C) begin
                  done_c = (sym_c == SYNC);
                  err_c  = (sym_c != SYNC);
               end else begin
                  err_c = (sym_c == GLITCH) || (sym_c == SYNC);
               end
            end
         end
         default: ;
      endcase
   end

   // Receiver FSM with registered outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         error_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         error_out <= 1'b0;
         case (state)
            IDLE: begin
               if (fall_c) begin
                  state <= HEAD;
               end
            end
            HEAD: begin
               if (err_c) begin
                  state     <= ERR;
                  error_out <= 1'b1;
               end else if (rise_c) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (err_c) begin
                  state     <= ERR;
                  error_out <= 1'b1;
               end else if (done_c) begin
                  state     <= IDLE;
                  data_out  <= shreg;
                  valid_out <= 1'b1;
               end else if (rise_c) begin
                  shreg   <= {shreg[FRAME_BITS-2:0], (sym_c == ONE)};
                  bit_cnt <= bit_cnt + BIT_CNT_W'(1);
               end
            end
            ERR: begin
               if (level && high_cnt == PERIOD_C) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_diff_rx.sv
// Self-checking bench for diff_rx: a behavioural transmitter drives
// frames onto the line and the expected frames are queued for comparison.
module tb_diff_rx;

   localparam int PERIOD = 20;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        line_in;
   logic [25:0] data_out;
   logic        valid_out;
   logic        error_out;
   logic [1:0]  state_out;

   int n_checks = 0;
   int n_pass   = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;
   bit overlap   = 1'b0;
   logic [25:0] got_q[$];
   logic [25:0] exp_q[$];
   logic [25:0] last_good = '0;

   diff_rx dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .line_in   (line_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .error_out (error_out),
      .state_out (state_out)
   );

   always #5 clk_in = ~clk_in;

   // Event recorder sampled away from the active edge.
   always @(negedge clk_in) begin
      if (valid_out) begin
         valid_cnt = valid_cnt + 1;
         got_q.push_back(data_out);
      end
      if (error_out) err_cnt = err_cnt + 1;
      if (valid_out && error_out) overlap = 1'b1;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      line_in = 1'b1;
      repeat (n) tick();
   endtask

   task automatic send_sym(input int low, input int high);
      line_in = 1'b0;
      repeat (low) tick();
      line_in = 1'b1;
      repeat (high) tick();
   endtask

   // kind: 0 = ZERO, 1 = ONE, 2 = SYNC; jitter stays inside each class.
   function automatic int pick_low(input int kind, input bit jitter);
      case (kind)
         0:       return jitter ? int'($urandom_range(7, 3))   : 5;
         1:       return jitter ? int'($urandom_range(17, 14)) : 15;
         default: return jitter ? int'($urandom_range(11, 9))  : 10;
      endcase
   endfunction

   task automatic send_head_bits(input logic [25:0] d, input int nbits, input bit jitter);
      int l;
      l = pick_low(2, jitter);
      send_sym(l, PERIOD - l);
      for (int i = 0; i < nbits; i++) begin
         l = pick_low(d[25-i] ? 1 : 0, jitter);
         send_sym(l, PERIOD - l);
      end
   endtask

   task automatic send_frame(input logic [25:0] d, input bit jitter, input int tail_high);
      int l;
      send_head_bits(d, 26, jitter);
      l = pick_low(2, jitter);
      send_sym(l, tail_high);
      exp_q.push_back(d);
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0;
      line_in  = 1'b1;
      repeat (3) tick();
      n_checks++; if (data_out !== 26'd0) $display("FAIL reset_data got %h want 0", data_out); else n_pass++;
      n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_out); else n_pass++;
      n_checks++; if (error_out !== 1'b0) $display("FAIL reset_error got %b want 0", error_out); else n_pass++;
      n_checks++; if (state_out !== 2'd0) $display("FAIL reset_state got %0d want 0", state_out); else n_pass++;
      rst_n_in = 1'b1;
      idle(5);
   endtask

   task automatic test_basic();
      int v0, e0;
      logic [25:0] g, e;
      v0 = valid_cnt; e0 = err_cnt;
      got_q.delete(); exp_q.delete();
      send_frame(26'h2AAAAAA, 1'b0, 0);
      tick();
      n_checks++; if (valid_out !== 1'b0) $display("FAIL lat_edge1 got %b want 0", valid_out); else n_pass++;
      tick();
      n_checks++; if (valid_out !== 1'b0) $display("FAIL lat_edge2 got %b want 0", valid_out); else n_pass++;
      tick();
      n_checks++; if (valid_out !== 1'b1) $display("FAIL lat_edge3 got %b want 1", valid_out); else n_pass++;
      n_checks++; if (data_out !== 26'h2AAAAAA) $display("FAIL lat_data got %h want 2aaaaaa", data_out); else n_pass++;
      idle(30);
      n_checks++; if (valid_cnt - v0 !== 1) $display("FAIL basic_valid_cnt got %0d want 1", valid_cnt - v0); else n_pass++;
      n_checks++; if (err_cnt - e0 !== 0) $display("FAIL basic_err_cnt got %0d want 0", err_cnt - e0); else n_pass++;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) $display("FAIL basic_frame got %h want %h", g, e); else n_pass++;
      end
      last_good = 26'h2AAAAAA;
   endtask

   task automatic test_back_to_back();
      int v0, e0;
      logic [25:0] g, e;
      v0 = valid_cnt; e0 = err_cnt;
      got_q.delete(); exp_q.delete();
      send_frame(26'h3FFFFFF, 1'b0, 1);
      send_frame(26'h0000000, 1'b0, 20);
      idle(10);
      n_checks++; if (valid_cnt - v0 !== 2) $display("FAIL b2b_valid_cnt got %0d want 2", valid_cnt - v0); else n_pass++;
      n_checks++; if (err_cnt - e0 !== 0) $display("FAIL b2b_err_cnt got %0d want 0", err_cnt - e0); else n_pass++;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) $display("FAIL b2b_frame got %h want %h", g, e); else n_pass++;
      end
      last_good = 26'h0000000;
   endtask

   task automatic test_random();
      int v0, e0;
      logic [25:0] d, g, e;
      v0 = valid_cnt; e0 = err_cnt;
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         d = 26'($urandom);
         send_frame(d, 1'b1, int'($urandom_range(20, 1)));
         last_good = d;
      end
      idle(30);
      n_checks++; if (valid_cnt - v0 !== 4) $display("FAIL rand_valid_cnt got %0d want 4", valid_cnt - v0); else n_pass++;
      n_checks++; if (err_cnt - e0 !== 0) $display("FAIL rand_err_cnt got %0d want 0", err_cnt - e0); else n_pass++;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) $display("FAIL rand_frame got %h want %h", g, e); else n_pass++;
      end
   endtask

   task automatic test_timeout();
      int v0, e0;
      bit seen;
      v0 = valid_cnt; e0 = err_cnt;
      seen = 1'b0;
      send_head_bits(26'($urandom), 11, 1'b1);
      line_in = 1'b1;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (error_out === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++; if (seen !== 1'b1) $display("FAIL trunc_error_seen got %b want 1", seen); else n_pass++;
      n_checks++; if (state_out !== 2'd3) $display("FAIL trunc_state_err got %0d want 3", state_out); else n_pass++;
      repeat (15) tick();
      n_checks++; if (state_out !== 2'd3) $display("FAIL trunc_state_hold got %0d want 3", state_out); else n_pass++;
      repeat (10) tick();
      n_checks++; if (state_out !== 2'd0) $display("FAIL trunc_state_idle got %0d want 0", state_out); else n_pass++;
      n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL trunc_valid_cnt got %0d want 0", valid_cnt - v0); else n_pass++;
      n_checks++; if (err_cnt - e0 !== 1) $display("FAIL trunc_err_cnt got %0d want 1", err_cnt - e0); else n_pass++;
      n_checks++; if (data_out !== last_good) $display("FAIL trunc_data_hold got %h want %h", data_out, last_good); else n_pass++;
   endtask

   task automatic test_glitch();
      int v0, e0;
      logic [25:0] g, e;
      v0 = valid_cnt; e0 = err_cnt;
      got_q.delete(); exp_q.delete();
      send_head_bits(26'h1234567, 5, 1'b0);
      // ZERO symbol with a one-cycle low glitch in its high phase
      send_sym(5, 5);
      send_sym(1, 9);
      idle(45);
      n_checks++; if (err_cnt - e0 !== 1) $display("FAIL glitch_err_cnt got %0d want 1", err_cnt - e0); else n_pass++;
      n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL glitch_valid_cnt got %0d want 0", valid_cnt - v0); else n_pass++;
      n_checks++; if (state_out !== 2'd0) $display("FAIL glitch_recover got %0d want 0", state_out); else n_pass++;
      send_frame(26'h1234567, 1'b0, 20);
      idle(10);
      n_checks++; if (valid_cnt - v0 !== 1) $display("FAIL glitch_next_valid got %0d want 1", valid_cnt - v0); else n_pass++;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) $display("FAIL glitch_next_frame got %h want %h", g, e); else n_pass++;
      end
      last_good = 26'h1234567;
   endtask

   task automatic test_stuck_low();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      idle(5);
      line_in = 1'b0;
      repeat (25) tick();
      idle(40);
      n_checks++; if (err_cnt - e0 !== 1) $display("FAIL stuck_err_cnt got %0d want 1", err_cnt - e0); else n_pass++;
      n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL stuck_valid_cnt got %0d want 0", valid_cnt - v0); else n_pass++;
      n_checks++; if (state_out !== 2'd0) $display("FAIL stuck_state got %0d want 0", state_out); else n_pass++;
      n_checks++; if (data_out !== last_good) $display("FAIL stuck_data_hold got %h want %h", data_out, last_good); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int v0, e0;
      logic [25:0] d, g, e;
      send_head_bits(26'($urandom), 15, 1'b1);
      line_in = 1'b0;
      repeat (3) tick();
      rst_n_in = 1'b0;
      #1;
      n_checks++; if (data_out !== 26'd0) $display("FAIL rstmid_data got %h want 0", data_out); else n_pass++;
      n_checks++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid got %b want 0", valid_out); else n_pass++;
      n_checks++; if (error_out !== 1'b0) $display("FAIL rstmid_error got %b want 0", error_out); else n_pass++;
      n_checks++; if (state_out !== 2'd0) $display("FAIL rstmid_state got %0d want 0", state_out); else n_pass++;
      last_good = '0;
      repeat (3) tick();
      line_in = 1'b1;
      repeat (2) tick();
      v0 = valid_cnt; e0 = err_cnt;
      rst_n_in = 1'b1;
      idle(40);
      n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL rstmid_valid_cnt got %0d want 0", valid_cnt - v0); else n_pass++;
      n_checks++; if (err_cnt - e0 !== 0) $display("FAIL rstmid_err_cnt got %0d want 0", err_cnt - e0); else n_pass++;
      got_q.delete(); exp_q.delete();
      d = 26'($urandom);
      send_frame(d, 1'b1, 20);
      idle(10);
      n_checks++; if (valid_cnt - v0 !== 1) $display("FAIL rstmid_next_valid got %0d want 1", valid_cnt - v0); else n_pass++;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_checks++; if (g !== e) $display("FAIL rstmid_next_frame got %h want %h", g, e); else n_pass++;
      end
      last_good = d;
   endtask

   task automatic test_reset_line_low();
      int v0, e0;
      rst_n_in = 1'b0;
      line_in  = 1'b0;
      repeat (3) tick();
      v0 = valid_cnt; e0 = err_cnt;
      rst_n_in = 1'b1;
      repeat (5) tick();
      idle(45);
      n_checks++; if (err_cnt - e0 !== 1) $display("FAIL rstlow_err_cnt got %0d want 1", err_cnt - e0); else n_pass++;
      n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL rstlow_valid_cnt got %0d want 0", valid_cnt - v0); else n_pass++;
      n_checks++; if (state_out !== 2'd0) $display("FAIL rstlow_state got %0d want 0", state_out); else n_pass++;
   endtask

   task automatic test_exclusive();
      n_checks++; if (overlap !== 1'b0) $display("FAIL valid_error_overlap got %b want 0", overlap); else n_pass++;
   endtask

   initial begin
      rst_n_in = 1'b0;
      line_in  = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_random();
      test_timeout();
      test_glitch();
      test_stuck_low();
      test_reset_mid();
      test_reset_line_low();
      test_exclusive();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/diff_rx.md
# diff_rx

Receive side of the single-wire pulse-width link. Recovers 26-bit frames from the serial line driven by the link transmitter and presents each complete frame on `data_out` with a one-cycle `valid_out` strobe. The line input is asynchronous to `clk_in`. Malformed frames are discarded and flagged on `error_out`.

## Interface
- `DATA_PERIOD`, 20: symbol period in `clk_in` cycles.
- `ZERO_MAX_LOW`, 7: largest low time, in cycles, classified as a ZERO.
- `SYNC_MAX_LOW`, 12: largest low time, in cycles, classified as SYNC. Low times above this and below `DATA_PERIOD` are classified as ONE.
- `MIN_LOW`, 2: any low pulse shorter than this is a glitch.
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `line_in`  in  1  serial line, asynchronous to `clk_in`; idles high.
- `data_out`  out  26  last good frame, MSB first on the wire; reset value 0.
- `valid_out`  out  1  one-cycle pulse when `data_out` updates; reset value 0.
- `error_out`  out  1  one-cycle pulse on a protocol violation; reset value 0.
- `state_out`  out  2  current FSM state encoding; reset value IDLE.

## Operation
- **Line encoding**
  - Every symbol starts with a falling edge. The symbol is defined by its low time L; the high time fills the rest of `DATA_PERIOD`.
  - Nominal low times at the default period: SYNC L=10, ZERO L=5, ONE L=15.
  - A frame is: SYNC, then 26 data bits MSB first, then a trailing SYNC, then the line stays high.
- **Front end**
  - 2-flop synchronizer followed by one delay flop for edge detection.
  - All three flops reset to 1, matching the idle line.
- **Low-time counter**
  - Loads 1 on each falling edge and increments every cycle while the line is low.
  - On each rising edge, L is classified:
    - L < `MIN_LOW`: GLITCH.
    - L ≤ `ZERO_MAX_LOW`: ZERO.
    - L ≤ `SYNC_MAX_LOW`: SYNC.
    - Otherwise: ONE.
  - If the counter reaches `DATA_PERIOD` while the line is still low: error (stuck low).
- **High-time counter**
  - Clears on each falling edge and increments while the line is high.
  - If it reaches `DATA_PERIOD` in state HEAD or DATA: error (truncated frame).
- **FSM states**
  - IDLE=0: a falling edge moves to HEAD.
  - HEAD=1: classification SYNC moves to DATA with `bit_cnt`=0. Any other classification is an error.
  - DATA=2, with `bit_cnt` < 26:
    - ZERO or ONE shifts the bit into the shift register (LSB in) and increments `bit_cnt`.
    - SYNC or GLITCH is an error.
  - DATA=2, with `bit_cnt` == 26:
    - SYNC loads `data_out` from the shift register, pulses `valid_out`, and returns to IDLE.
    - Anything else is an error.
  - ERR=3: entered on any error, with a one-cycle `error_out` pulse. Returns to IDLE after the line has been high for `DATA_PERIOD` consecutive cycles.
- **Output holding**
  - `data_out` holds its value across errors and idle periods.
  - `valid_out` and `error_out` are never asserted in the same cycle.

## Timing
- **Valid latency**
  - Count the first `clk_in` edge that samples `line_in` high at the end of the trailing SYNC low as edge 1.
  - `valid_out` and `data_out` update on edge 3.
- **Error latency**
  - `error_out` follows the same 3-edge latency relative to the offending edge or timeout.
- **Back-to-back frames**
  - Frames separated by only one idle-high cycle must both decode, because IDLE accepts a falling edge on its first cycle.
- **Measurement accuracy**
  - The synchronizer delays both edges equally, so L equals the transmitted low time exactly (±1 cycle when the edge is metastable).
- **Reset behaviour**
  - Reset asserted at any time clears all outputs, counters and the FSM immediately; no `valid_out` is produced for the interrupted frame.
  - Release with the line low is treated as a falling edge. The resulting partial frame must end in `error_out`, never in `valid_out`.

## Structure
- **Package `diff_pkg`**
  - Constant `FRAME_BITS` = 26.
  - `rx_state_t` enum: IDLE, HEAD, DATA, ERR.
  - `symbol_t` enum: GLITCH, ZERO, SYNC, ONE.
  - The transmitter's state enum also moves into this package.
- **Sub-module `line_sync_edge`**
  - 2-flop synchronizer plus delay flop, with reset value 1.
  - Outputs: synchronized line level, rise pulse, fall pulse.
- The top level holds the counters, the classifier and the FSM.

## Test plan
- Transmitter model sends 26'h2AAAAAA at the default period -> exactly one `valid_out`, `data_out`=26'h2AAAAAA, `error_out` never asserted.
- Frame 26'h3FFFFFF, then one idle cycle, then frame 26'h0000000 -> two `valid_out` pulses with the correct data in order.
- Line held high for 20 cycles after bit 10 of a frame -> `error_out` pulse, `valid_out` never asserted, `data_out` unchanged, `state_out`=IDLE after 20 further high cycles.
- A 1-cycle low glitch inside the high phase of a ZERO symbol -> `error_out`, recovery to IDLE, next clean frame 26'h1234567 decodes correctly.
- Line held low for 25 cycles -> `error_out` on reaching 20 low cycles, no `valid_out`.
- `rst_n_in` pulsed low during bit 15 of a frame -> all outputs 0 immediately, no `valid_out` for that frame, next frame decodes correctly.
